// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR coefficient controller.
package fir_pkg;

    // Unique (half-symmetric) coefficients per filter
    localparam int NCOEF = 12;
    // Coefficient width, signed two's complement
    localparam int CW    = 21;
    // Coefficient address width (2**AW >= NCOEF)
    localparam int AW    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } state_t;

    // Every coefficient index has been written since the last swap
    localparam logic [NCOEF-1:0] MASK_FULL = '1;

endpackage

// File: rtl/fir_coeff_bank.sv
// NCOEF x CW coefficient register file: single write port, bulk copy, flat output.
module fir_coeff_bank
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [AW-1:0]           addr,
    input  logic signed [CW-1:0]    data,
    input  logic                    load,
    input  logic [NCOEF*CW-1:0]     load_data,
    output logic [NCOEF*CW-1:0]     q
);

    // Bulk copy wins over a single-entry write; entry k lives at q[k*CW +: CW]
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (we) begin
            for (int k = 0; k < NCOEF; k++) begin
                if (addr == AW'(k)) begin
                    q[k*CW +: CW] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// Coefficient configuration controller: shadow-bank loading with a written-index
// mask, commit arming, and a sample-aligned swap into the active bank.
module fir_coeff_ctrl
    import fir_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [AW-1:0]           cfg_addr,
    input  logic signed [CW-1:0]    cfg_data,
    input  logic                    cfg_commit,
    input  logic                    sample_strobe,
    output logic [NCOEF*CW-1:0]     coeff_active,
    output logic                    busy,
    output logic                    swap_done,
    output logic                    err
);

    localparam logic [AW:0] NCOEF_LIM = (AW+1)'(NCOEF);

    state_t              state;
    state_t              state_nxt;
    logic [NCOEF-1:0]    mask;
    logic [NCOEF-1:0]    mask_nxt;
    logic [NCOEF-1:0]    mask_wr;
    logic                wr_acc;
    logic                wr_ok;
    logic                wr_bad;
    logic                commit_ok;
    logic                commit_bad;
    logic                swap;
    logic                err_nxt;
    logic [NCOEF*CW-1:0] shadow_q;

    assign cfg_ready = (state != ARMED);
    assign busy      = (state == ARMED);

    // Request decode; a commit sees the mask including a same-cycle write
    always_comb begin
        wr_acc     = cfg_valid && cfg_ready;
        wr_ok      = wr_acc && ({1'b0, cfg_addr} < NCOEF_LIM);
        wr_bad     = wr_acc && !({1'b0, cfg_addr} < NCOEF_LIM);
        mask_wr    = mask | (wr_ok ? (NCOEF'(1) << cfg_addr) : '0);
        commit_ok  = cfg_commit && (state != ARMED) && (mask_wr == MASK_FULL);
        commit_bad = cfg_commit && (state != ARMED) && (mask_wr != MASK_FULL);
        swap       = (state == ARMED) && sample_strobe;
        err_nxt    = wr_bad || commit_bad;
    end

    // Next-state and mask update; a strobe is only honoured once ARMED
    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        case (state)
            IDLE, LOAD: begin
                if (wr_ok) begin
                    mask_nxt  = mask_wr;
                    state_nxt = LOAD;
                end
                if (commit_ok) begin
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (sample_strobe) begin
                    mask_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                mask_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Control registers and registered status pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mask      <= '0;
            err       <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            mask      <= mask_nxt;
            err       <= err_nxt;
            swap_done <= swap;
        end
    end

    fir_coeff_bank u_shadow (
        .clk       (clk),
        .reset     (reset),
        .we        (wr_ok),
        .addr      (cfg_addr),
        .data      (cfg_data),
        .load      (1'b0),
        .load_data ('0),
        .q         (shadow_q)
    );

    fir_coeff_bank u_active (
        .clk       (clk),
        .reset     (reset),
        .we        (1'b0),
        .addr      ('0),
        .data      ('0),
        .load      (swap),
        .load_data (shadow_q),
        .q         (coeff_active)
    );

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Self-checking bench for fir_coeff_ctrl: directed steps plus a randomized phase,
// compared every cycle against an array-based reference model.
module tb_fir_coeff_ctrl;
    import fir_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   cfg_valid = 1'b0;
    logic                   cfg_ready;
    logic [AW-1:0]          cfg_addr = '0;
    logic signed [CW-1:0]   cfg_data = '0;
    logic                   cfg_commit = 1'b0;
    logic                   sample_strobe = 1'b0;
    logic [NCOEF*CW-1:0]    coeff_active;
    logic                   busy;
    logic                   swap_done;
    logic                   err;

    int checks = 0;
    int errors = 0;

    logic [CW-1:0] m_sh  [NCOEF];
    logic [CW-1:0] m_act [NCOEF];
    bit            m_wr  [NCOEF];
    bit            m_armed;
    bit            m_swap;
    bit            m_err;
    logic [CW-1:0] saved;

    fir_coeff_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_addr      (cfg_addr),
        .cfg_data      (cfg_data),
        .cfg_commit    (cfg_commit),
        .sample_strobe (sample_strobe),
        .coeff_active  (coeff_active),
        .busy          (busy),
        .swap_done     (swap_done),
        .err           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [NCOEF*CW-1:0] obs,
                       input logic [NCOEF*CW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NCOEF*CW-1:0] pack_act();
        logic [NCOEF*CW-1:0] p;
        for (int k = 0; k < NCOEF; k++) p[k*CW +: CW] = m_act[k];
        return p;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCOEF; k++) begin
            m_sh[k]  = '0;
            m_act[k] = '0;
            m_wr[k]  = 1'b0;
        end
        m_armed = 1'b0;
        m_swap  = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic check_outputs(input string where);
        chk({where, ":swap_done"},    swap_done,    m_swap);
        chk({where, ":err"},          err,          m_err);
        chk({where, ":busy"},         busy,         m_armed);
        chk({where, ":cfg_ready"},    cfg_ready,    !m_armed);
        chk({where, ":coeff_active"}, coeff_active, pack_act());
    endtask

    // One clock cycle of stimulus, model update and output check
    task automatic cyc(input bit v, input int a, input logic [CW-1:0] d,
                       input bit c, input bit s);
        bit full;
        bit bad;
        cfg_valid     = v;
        cfg_addr      = AW'(a);
        cfg_data      = d;
        cfg_commit    = c;
        sample_strobe = s;
        bad    = 1'b0;
        m_swap = 1'b0;
        if (!m_armed) begin
            if (v) begin
                if (a < NCOEF) begin
                    m_sh[a] = d;
                    m_wr[a] = 1'b1;
                end else begin
                    bad = 1'b1;
                end
            end
            if (c) begin
                full = 1'b1;
                for (int k = 0; k < NCOEF; k++) if (!m_wr[k]) full = 1'b0;
                if (full) m_armed = 1'b1;
                else      bad = 1'b1;
            end
        end else if (s) begin
            for (int k = 0; k < NCOEF; k++) begin
                m_act[k] = m_sh[k];
                m_wr[k]  = 1'b0;
            end
            m_armed = 1'b0;
            m_swap  = 1'b1;
        end
        m_err = bad;
        @(posedge clk);
        #1;
        cfg_valid     = 1'b0;
        cfg_commit    = 1'b0;
        sample_strobe = 1'b0;
        check_outputs("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < NCOEF; k++) cyc(1'b1, k, CW'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        #1 reset = 1'b1;
        #2 check_outputs("reset_async");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        check_outputs("reset_release");
        chk("reset_coeff_zero", coeff_active, '0);

        // Full bank 0x100+k, commit, strobe five cycles later
        for (int k = 0; k < NCOEF; k++) cyc(1'b1, k, CW'(21'h00100 + k), 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        idle(4);
        cyc(1'b0, 0, '0, 1'b0, 1'b1);
        chk("first_swap_done", swap_done, 1'b1);
        for (int k = 0; k < NCOEF; k++)
            chk($sformatf("first_field%0d", k), coeff_active[k*CW +: CW], CW'(21'h00100 + k));
        idle(1);
        chk("first_swap_done_fall", swap_done, 1'b0);
        chk("first_busy_low", busy, 1'b0);

        // Partial bank commit rejected; strobe does nothing; final write plus commit arms
        for (int k = 0; k < NCOEF - 1; k++) cyc(1'b1, k, CW'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        chk("partial_commit_err", err, 1'b1);
        cyc(1'b0, 0, '0, 1'b0, 1'b1);
        chk("partial_no_swap", swap_done, 1'b0);
        cyc(1'b1, NCOEF - 1, CW'($urandom), 1'b1, 1'b0);
        chk("last_write_commit_busy", busy, 1'b1);
        idle(2);
        cyc(1'b0, 0, '0, 1'b0, 1'b1);
        chk("late_swap_done", swap_done, 1'b1);

        // Out-of-range writes, then bad write with failed commit in one cycle
        cyc(1'b1, 12, CW'(21'h0ABCDE), 1'b0, 1'b0);
        chk("bad_addr12_err", err, 1'b1);
        cyc(1'b1, 15, CW'(21'h012345), 1'b0, 1'b0);
        chk("bad_addr15_err", err, 1'b1);
        cyc(1'b1, 13, CW'(21'h000001), 1'b1, 1'b0);
        chk("bad_both_err", err, 1'b1);
        idle(1);
        chk("bad_both_single", err, 1'b0);

        // Write attempt while armed is refused
        fill_random();
        saved = m_sh[3];
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        cfg_valid = 1'b1;
        cfg_addr  = AW'(3);
        #1 chk("armed_ready_low", cfg_ready, 1'b0);
        cyc(1'b1, 3, CW'(21'h1FFFFF), 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b0, 1'b1);
        chk("armed_write_ignored", coeff_active[3*CW +: CW], saved);

        // Commit and strobe together: swap waits for the next strobe
        fill_random();
        cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("commit_strobe_no_swap", swap_done, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b1);
        chk("next_strobe_swap", swap_done, 1'b1);

        // Reset while armed discards the swap
        fill_random();
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs("reset_armed");
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(1'b0, 0, '0, 1'b0, 1'b1);
        chk("post_reset_no_swap", swap_done, 1'b0);

        // Negative coefficient at index 0
        cyc(1'b1, 0, CW'(21'h1E0000), 1'b0, 1'b0);
        for (int k = 1; k < NCOEF; k++) cyc(1'b1, k, CW'(21'h00200 + k), 1'b0, 1'b0);
        cyc(1'b0, 0, '0, 1'b1, 1'b0);
        cyc(1'b0, 0, '0, 1'b0, 1'b1);
        chk("neg_field0", coeff_active[CW-1:0], CW'(21'h1E0000));
        chk("neg_field1", coeff_active[CW +: CW], CW'(21'h00201));

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int a;
            a = ($urandom_range(0, 19) == 0) ? 12 + int'($urandom_range(0, 3))
                                             : int'($urandom_range(0, NCOEF - 1));
            cyc($urandom_range(0, 9) < 7, a, CW'($urandom),
                $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
